// File: rtl/if_fetch_if.sv
// Instruction-memory request/response channel for the IF stage.
// master = fetch unit, slave = instruction memory.
interface if_fetch_if;
    logic        req;
    logic [63:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/if_fetch.sv
// IF-stage fetch unit: one outstanding imem request, redirect with stale drop.
// Optional perf counters enabled by defining IF_FETCH_PERF_EN.
module if_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  ctrl_signal_i,
    input  logic        redirect_valid_i,
    input  logic [63:0] redirect_pc_i,
    if_fetch_if.master  imem,
    output logic [63:0] pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [63:0] perf_fetch_cnt_o,
    output logic [31:0] perf_drop_cnt_o,
    output logic [63:0] perf_stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state_q;
    logic [63:0] pc_q;
    logic        drop_q;
    logic [31:0] inst_q;
    logic        valid_q;
    logic        req_q;
    logic        stalled;

    assign stalled    = (ctrl_signal_i == 2'b01);
    assign imem.req   = req_q;
    assign imem.addr  = pc_q;
    assign pc_o       = pc_q;
    assign if_valid_o = valid_q;
    assign if_inst_o  = valid_q ? inst_q : NOP_INST;

    // Fetch FSM: request, wait for response, hold until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
`ifdef IF_FETCH_PERF_EN
            perf_fetch_cnt_o <= '0;
            perf_drop_cnt_o  <= '0;
            perf_stall_cnt_o <= '0;
`endif
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (redirect_valid_i) begin
                        pc_q <= redirect_pc_i;
                    end
                    if (imem.gnt) begin
                        state_q <= S_WAIT;
                        req_q   <= 1'b0;
                        // granted beat belongs to the old address
                        drop_q  <= redirect_valid_i;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid_i) begin
                        pc_q <= redirect_pc_i;
                    end
                    if (imem.rvalid) begin
                        if (drop_q || redirect_valid_i) begin
                            drop_q  <= 1'b0;
                            state_q <= S_REQ;
                            req_q   <= 1'b1;
`ifdef IF_FETCH_PERF_EN
                            perf_drop_cnt_o <= perf_drop_cnt_o + 32'd1;
`endif
                        end else begin
                            inst_q  <= imem.rdata;
                            valid_q <= 1'b1;
                            state_q <= S_HOLD;
                        end
                    end else if (redirect_valid_i) begin
                        drop_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid_i) begin
                        pc_q    <= redirect_pc_i;
                        valid_q <= 1'b0;
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                    end else if (!stalled) begin
                        pc_q    <= pc_q + 64'd4;
                        valid_q <= 1'b0;
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
`ifdef IF_FETCH_PERF_EN
                        perf_fetch_cnt_o <= perf_fetch_cnt_o + 64'd1;
`endif
                    end else begin
`ifdef IF_FETCH_PERF_EN
                        perf_stall_cnt_o <= perf_stall_cnt_o + 64'd1;
`endif
                    end
                end
                default: begin
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios then randomized traffic
// against a transaction-level model of the fetch stream.
module tb_if_fetch;

    localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  ctrl = 2'b00;
    logic        redir = 1'b0;
    logic [63:0] rpc = '0;
    logic [63:0] pc_o;
    logic [31:0] inst_o;
    logic        valid_o;
`ifdef IF_FETCH_PERF_EN
    logic [63:0] pf_fetch;
    logic [31:0] pf_drop;
    logic [63:0] pf_stall;
`endif

    if_fetch_if imem ();

    if_fetch dut (
        .clk              (clk),
        .rst              (rst),
        .ctrl_signal_i    (ctrl),
        .redirect_valid_i (redir),
        .redirect_pc_i    (rpc),
        .imem             (imem),
        .pc_o             (pc_o),
        .if_inst_o        (inst_o),
        .if_valid_o       (valid_o)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_fetch_cnt_o (pf_fetch),
        .perf_drop_cnt_o  (pf_drop),
        .perf_stall_cnt_o (pf_stall)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // fetch-stream model: architectural PC, held instruction, one outstanding
    logic [63:0] m_pc;
    logic        m_valid;
    logic [31:0] m_inst;
    logic        m_out;
    logic        m_taint;
    logic        m_req;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = RPC;
        m_valid = 1'b0;
        m_inst  = NOP;
        m_out   = 1'b0;
        m_taint = 1'b0;
        m_req   = 1'b1;
    endtask

    task automatic check_outputs();
        chk("addr", imem.addr, m_pc);
        chk("pc", pc_o, m_pc);
        chk("req", 64'(imem.req), 64'(m_req));
        chk("valid", 64'(valid_o), 64'(m_valid));
        chk("inst", 64'(inst_o), 64'(m_valid ? m_inst : NOP));
    endtask

    // called at a negedge: check, drive one cycle of inputs, advance model
    task automatic cycle(input logic g, input logic rv,
                         input logic [31:0] rd, input logic rdr,
                         input logic [63:0] rp, input logic [1:0] c);
        logic deliver;
        logic clean;
        check_outputs();
        imem.gnt    = g;
        imem.rvalid = rv;
        imem.rdata  = rd;
        redir       = rdr;
        rpc         = rp;
        ctrl        = c;
        deliver = rv && m_out;
        clean   = deliver && !m_taint && !rdr;
        if (deliver) m_out = 1'b0;
        if (rdr) begin
            m_pc    = rp;
            m_valid = 1'b0;
            m_taint = 1'b1;
        end else if (m_valid && c != 2'b01) begin
            m_pc    = m_pc + 64'd4;
            m_valid = 1'b0;
        end
        if (g && m_req) begin
            m_out   = 1'b1;
            m_taint = rdr;
        end
        if (clean) begin
            m_valid = 1'b1;
            m_inst  = rd;
        end
        m_req = !m_out && !m_valid;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic [1:0] c);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, c);
    endtask

    initial begin
        int wt;
        logic g, rv, rdr;
        logic [63:0] rp;
        logic [1:0] c;

        imem.gnt    = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // first fetch: grant, respond next cycle, consume
        chk("rst_req", 64'(imem.req), 64'd1);
        chk("rst_inst", 64'(inst_o), 64'(NOP));
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 2'b00);
        cycle(1'b0, 1'b1, 32'h0000_0093, 1'b0, 64'h0, 2'b00);
        chk("first_valid", 64'(valid_o), 64'd1);
        chk("first_pc", pc_o, 64'h8000_0000);
        chk("first_inst", 64'(inst_o), 64'h93);
        idle(2'b00);
        chk("second_addr", imem.addr, 64'h8000_0004);

        // stall for 5 cycles in HOLD
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 2'b00);
        cycle(1'b0, 1'b1, 32'h1234_5678, 1'b0, 64'h0, 2'b00);
        repeat (5) idle(2'b01);
        chk("stall_pc", pc_o, 64'h8000_0004);
        chk("stall_inst", 64'(inst_o), 64'h1234_5678);
        chk("stall_noreq", 64'(imem.req), 64'd0);
        idle(2'b10);
        chk("after_stall_addr", imem.addr, 64'h8000_0008);

        // redirect while waiting, stale response discarded
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 2'b00);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 64'h8000_1000, 2'b00);
        cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 64'h0, 2'b00);
        chk("wait_redir_valid", 64'(valid_o), 64'd0);
        chk("wait_redir_addr", imem.addr, 64'h8000_1000);

        // redirect coincident with grant
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 64'h8000_2000, 2'b00);
        cycle(1'b0, 1'b1, 32'h0000_AAAA, 1'b0, 64'h0, 2'b00);
        chk("gnt_redir_valid", 64'(valid_o), 64'd0);
        chk("gnt_redir_req", 64'(imem.req), 64'd1);
        chk("gnt_redir_addr", imem.addr, 64'h8000_2000);

        // PC wrap
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 2'b00);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 2'b00);
        cycle(1'b0, 1'b1, 32'h1357_9BDF, 1'b0, 64'h0, 2'b00);
        chk("wrap_pc", pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
        idle(2'b00);
        chk("wrap_addr", imem.addr, 64'h0);

        // reset during WAIT; old response arrives right after reset
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 2'b00);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 64'h0, 2'b00);
        chk("rst_stale_valid", 64'(valid_o), 64'd0);
        chk("rst_stale_addr", imem.addr, RPC);
        chk("rst_stale_inst", 64'(inst_o), 64'(NOP));

        // randomized traffic
        wt = 0;
        for (int i = 0; i < 600; i++) begin
            g   = m_req && ($urandom_range(0, 1) == 1);
            rv  = m_out && (wt == 0);
            rdr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1)
                rp = {$urandom, $urandom};
            else
                rp = RPC + 64'({$urandom_range(0, 255), 2'b00});
            if ($urandom_range(0, 1) == 1)
                c = 2'b01;
            else
                c = 2'($urandom_range(0, 3));
            if (!rv && $urandom_range(0, 7) == 0 && !m_out)
                rv = 1'b1;
            cycle(g, rv, $urandom, rdr, rp, c);
            if (g)
                wt = $urandom_range(0, 2);
            else if (m_out && wt > 0)
                wt--;
        end
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- IF-stage instruction fetch unit; the producer side of the IF/ID pipeline register.
- Owns the fetch PC and issues one request at a time to instruction memory over a req/gnt/rvalid handshake.
- Holds each returned instruction on pc_o/if_inst_o until the pipeline consumes it (ctrl not Stalled).
- Handles branch/exception redirects, including discarding in-flight stale responses.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset
- NOP_INST, 32'h0000_0013, value driven on if_inst_o when no valid instruction is held

Ports:
- clk  input  1  clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- ctrl_signal_i  input  2  pipeline control: 2'b01 = Stalled (hold); any other value = Default (consume)
- redirect_valid_i  input  1  redirect the fetch stream this cycle
- redirect_pc_i  input  64  redirect target
- imem_req_o  output  1  fetch request valid
- imem_addr_o  output  64  fetch address
- imem_gnt_i  input  1  request accepted this cycle
- imem_rvalid_i  input  1  response data valid
- imem_rdata_i  input  32  instruction word
- pc_o  output  64  PC of the held instruction (equals the current fetch PC)
- if_inst_o  output  32  held instruction, or NOP_INST when if_valid_o=0
- if_valid_o  output  1  pc_o/if_inst_o carry a real fetched instruction

Behaviour:
- Reset (rst=1 at posedge):
  - state=REQ, pc_q=RESET_PC, drop_q=0, inst_q=NOP_INST, if_valid_o=0.
  - imem_req_o=1 and imem_addr_o=RESET_PC from the first cycle with rst=0.
- Output assignments: imem_addr_o=pc_q; pc_o=pc_q.
- imem_req_o=1 only in state REQ. imem_addr_o may change while a request is not yet granted.
- State REQ:
  - imem_gnt_i=1 -> WAIT.
  - Redirect in the same cycle: pc_q<=redirect_pc_i and drop_q<=1. The grant belongs to the old address, so its response is discarded.
  - Redirect without grant: pc_q<=redirect_pc_i, stay in REQ.
- State WAIT:
  - imem_rvalid_i=1 with drop_q=0 and no redirect: inst_q<=imem_rdata_i, if_valid_o<=1, -> HOLD.
  - imem_rvalid_i=1 with drop_q=1 or a redirect this cycle: discard data, drop_q<=0, -> REQ. A same-cycle redirect also loads pc_q.
  - Redirect without rvalid: pc_q<=redirect_pc_i, drop_q<=1, stay in WAIT.
- State HOLD:
  - Redirect has priority: pc_q<=redirect_pc_i, if_valid_o<=0, -> REQ.
  - Else, ctrl_signal_i!=2'b01: instruction consumed at this edge; pc_q<=pc_q+4 (mod 2^64, wraps 0xFFFF_FFFF_FFFF_FFFC->0), if_valid_o<=0, -> REQ.
  - Else (Stalled): hold all outputs.
- imem_rvalid_i outside WAIT is ignored, e.g. a stale response after a mid-transaction reset.
- Latency:
  - gnt in cycle N; rvalid in cycle N+1 at the earliest; if_valid_o=1 from cycle N+2.
  - Best-case throughput: one instruction per 3 cycles. Only one request is ever outstanding.
- Redirect is not gated by Stalled; it always takes effect at the next edge.
- redirect_pc_i is used unmodified; the block performs no alignment check.

Optional Feature:
- Macro: IF_FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetch_cnt_o[63:0], incremented on each consumed instruction (HOLD exit with no redirect and not Stalled).
  - Adds outputs perf_drop_cnt_o[31:0], incremented on each discarded response.
  - Adds outputs perf_stall_cnt_o[63:0], incremented on each HOLD cycle with ctrl=Stalled and no redirect.
  - All counters reset to 0 and wrap silently.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release; imem grants immediately and returns 32'h0000_0093 next cycle; ctrl=Default -> addr 0x8000_0000 then 0x8000_0004; if_valid_o=1 with pc_o=0x8000_0000, inst 0x0000_0093 two cycles after grant; next request one cycle later.
- Instruction held, ctrl=Stalled for 5 cycles -> pc_o/if_inst_o/if_valid_o unchanged and no imem_req_o; on return to Default, the next request is to pc+4.
- Redirect to 0x8000_1000 in WAIT, response 32'hDEAD_BEEF one cycle later -> response discarded, if_valid_o stays 0, next request addr 0x8000_1000.
- Redirect coincident with gnt in REQ -> following rvalid discarded; the new request targets the redirect address.
- Redirect to 0xFFFF_FFFF_FFFF_FFFC, instruction consumed -> next fetch addr 0x0.
- rst asserted during WAIT, with the old response arriving in the first cycle after reset -> response ignored, addr=RESET_PC, if_valid_o=0, if_inst_o=0x0000_0013.
